// File: rtl/snn_input_packet_feeder.sv
// Host-side packet/frame source for the grid input-buffer interface; one closed frame is released per tick.
// Pop latency 1 cycle (ren -> packet_in); input_buffer_empty depends only on registered state.
module snn_input_packet_feeder #(
    parameter int PACKET_WIDTH = 30,
    parameter int DEPTH        = 4096,
    parameter int FRAME_DEPTH  = 128,
    parameter int CNT_W        = $clog2(DEPTH) + 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          wr_en,
    input  logic [PACKET_WIDTH-1:0]       wr_packet,
    input  logic                          frame_close,
    output logic                          wr_ready,
    output logic                          frame_ready,
    input  logic                          tick,
    input  logic                          ren_to_input_buffer,
    output logic [PACKET_WIDTH-1:0]       packet_in,
    output logic                          input_buffer_empty,
    output logic [$clog2(FRAME_DEPTH):0]  frames_pending,
    output logic                          wr_overflow,
    output logic                          frame_overflow,
    output logic                          tick_underrun,
    output logic                          frame_truncated,
    output logic                          ren_while_empty,
    output logic [CNT_W-1:0]              dropped_count
);
    localparam int AW  = $clog2(DEPTH);
    localparam int FAW = $clog2(FRAME_DEPTH);
    localparam int FPW = FAW + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACTIVE  = 2'd1;
    localparam logic [1:0] S_DRAINED = 2'd2;

    logic [PACKET_WIDTH-1:0] mem  [DEPTH];
    logic [CNT_W-1:0]        fmem [FRAME_DEPTH];

    logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        level_q, level_d, open_count_q, open_count_d;
    logic [CNT_W-1:0]        remaining_q, remaining_d, dropped_q, dropped_d;
    logic [FAW-1:0]          ff_wr_ptr_q, ff_wr_ptr_d, ff_rd_ptr_q, ff_rd_ptr_d;
    logic [FPW-1:0]          frames_pending_q, frames_pending_d;
    logic [1:0]              state_q, state_d;
    logic [PACKET_WIDTH-1:0] packet_in_q;
    logic                    wr_ovf_q, fr_ovf_q, underrun_q, trunc_q, ren_empty_q;

    logic                    wr_acc, fc_acc, pop, ff_pop;
    logic [CNT_W-1:0]        rem_after, drop_cnt, frame_cnt;
    logic [CNT_W:0]          drop_sum;

    assign wr_ready    = (level_q != CNT_W'(DEPTH));
    assign frame_ready = (frames_pending_q != FPW'(FRAME_DEPTH));
    assign wr_acc      = wr_en & wr_ready;
    assign fc_acc      = frame_close & frame_ready;
    assign pop         = ren_to_input_buffer & (state_q == S_ACTIVE);
    assign ff_pop      = tick & (frames_pending_q != '0);
    assign frame_cnt   = fmem[ff_rd_ptr_q];

    // Truncation acts on whatever is left after a same-cycle pop.
    assign rem_after   = remaining_q - CNT_W'(pop);
    assign drop_cnt    = tick ? rem_after : '0;
    assign drop_sum    = {1'b0, dropped_q} + {1'b0, drop_cnt};

    always_comb begin
        wr_ptr_d         = wr_ptr_q + AW'(wr_acc);
        rd_ptr_d         = rd_ptr_q + AW'(pop) + drop_cnt[AW-1:0];
        level_d          = level_q + CNT_W'(wr_acc) - CNT_W'(pop) - drop_cnt;
        open_count_d     = fc_acc ? '0 : open_count_q + CNT_W'(wr_acc);
        ff_wr_ptr_d      = ff_wr_ptr_q + FAW'(fc_acc);
        ff_rd_ptr_d      = ff_rd_ptr_q + FAW'(ff_pop);
        frames_pending_d = frames_pending_q + FPW'(fc_acc) - FPW'(ff_pop);
        dropped_d        = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        remaining_d      = rem_after;
        state_d          = state_q;
        if (state_q == S_ACTIVE && rem_after == '0) begin
            state_d = S_DRAINED;
        end
        if (tick) begin
            if (ff_pop) begin
                remaining_d = frame_cnt;
                state_d     = (frame_cnt != '0) ? S_ACTIVE : S_DRAINED;
            end else begin
                remaining_d = '0;
                state_d     = S_DRAINED;
            end
        end
    end

    // Storage arrays carry no reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= wr_packet;
        end
        if (fc_acc) begin
            fmem[ff_wr_ptr_q] <= open_count_q + CNT_W'(wr_acc);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            level_q          <= '0;
            open_count_q     <= '0;
            remaining_q      <= '0;
            dropped_q        <= '0;
            ff_wr_ptr_q      <= '0;
            ff_rd_ptr_q      <= '0;
            frames_pending_q <= '0;
            state_q          <= S_IDLE;
            packet_in_q      <= '0;
            wr_ovf_q         <= 1'b0;
            fr_ovf_q         <= 1'b0;
            underrun_q       <= 1'b0;
            trunc_q          <= 1'b0;
            ren_empty_q      <= 1'b0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            level_q          <= level_d;
            open_count_q     <= open_count_d;
            remaining_q      <= remaining_d;
            dropped_q        <= dropped_d;
            ff_wr_ptr_q      <= ff_wr_ptr_d;
            ff_rd_ptr_q      <= ff_rd_ptr_d;
            frames_pending_q <= frames_pending_d;
            state_q          <= state_d;
            if (pop) begin
                packet_in_q <= mem[rd_ptr_q];
            end
            wr_ovf_q    <= wr_ovf_q | (wr_en & ~wr_ready);
            fr_ovf_q    <= fr_ovf_q | (frame_close & ~frame_ready);
            underrun_q  <= underrun_q | (tick & ~ff_pop);
            trunc_q     <= trunc_q | (tick & (rem_after != '0));
            ren_empty_q <= ren_empty_q | (ren_to_input_buffer & (state_q != S_ACTIVE));
        end
    end

    assign packet_in          = packet_in_q;
    assign input_buffer_empty = (state_q != S_ACTIVE);
    assign frames_pending     = frames_pending_q;
    assign dropped_count      = dropped_q;
    assign wr_overflow        = wr_ovf_q;
    assign frame_overflow     = fr_ovf_q;
    assign tick_underrun      = underrun_q;
    assign frame_truncated    = trunc_q;
    assign ren_while_empty    = ren_empty_q;

endmodule

// File: tb/tb_snn_input_packet_feeder.sv
// Directed bench for snn_input_packet_feeder: vector table for basic frames, hand sequences for corner cases.
module tb_snn_input_packet_feeder;
    localparam int PW    = 30;
    localparam int DEPTH = 4096;
    localparam int FD    = 128;
    localparam int CW    = 13;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          wr_en, frame_close, tick, ren;
    logic [PW-1:0] wr_packet;
    logic          wr_ready, frame_ready, empty;
    logic [PW-1:0] packet_in;
    logic [7:0]    frames_pending;
    logic          wr_overflow, frame_overflow, tick_underrun, frame_truncated, ren_while_empty;
    logic [CW-1:0] dropped_count;

    int checks = 0;
    int errors = 0;

    snn_input_packet_feeder #(.PACKET_WIDTH(PW), .DEPTH(DEPTH), .FRAME_DEPTH(FD), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_packet(wr_packet),
        .frame_close(frame_close), .wr_ready(wr_ready), .frame_ready(frame_ready),
        .tick(tick), .ren_to_input_buffer(ren), .packet_in(packet_in),
        .input_buffer_empty(empty), .frames_pending(frames_pending),
        .wr_overflow(wr_overflow), .frame_overflow(frame_overflow),
        .tick_underrun(tick_underrun), .frame_truncated(frame_truncated),
        .ren_while_empty(ren_while_empty), .dropped_count(dropped_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          we;
        logic [PW-1:0] pk;
        logic          fc;
        logic          tk;
        logic          rn;
        logic          e_empty;
        logic [7:0]    e_fp;
        logic          c_pkt;
        logic [PW-1:0] e_pkt;
    } vec_t;

    vec_t vt [18];

    function automatic vec_t mk(input logic we, input logic [PW-1:0] pk, input logic fc,
                                input logic tk, input logic rn, input logic e_empty,
                                input logic [7:0] e_fp, input logic c_pkt, input logic [PW-1:0] e_pkt);
        vec_t v;
        v.we = we; v.pk = pk; v.fc = fc; v.tk = tk; v.rn = rn;
        v.e_empty = e_empty; v.e_fp = e_fp; v.c_pkt = c_pkt; v.e_pkt = e_pkt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: drive on the falling edge, outputs settle 1 time unit after the rising edge.
    task automatic cyc(input logic we, input logic [PW-1:0] pk, input logic fc,
                       input logic tk, input logic rn);
        @(negedge clk);
        wr_en = we; wr_packet = pk; frame_close = fc; tick = tk; ren = rn;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; wr_en = 0; wr_packet = '0; frame_close = 0; tick = 0; ren = 0;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic chk_reset_state();
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_pkt", {2'd0, packet_in}, 32'd0);
        chk("rst_fp", {24'd0, frames_pending}, 32'd0);
        chk("rst_drop", {19'd0, dropped_count}, 32'd0);
        chk("rst_flags", {27'd0, wr_overflow, frame_overflow, tick_underrun, frame_truncated, ren_while_empty}, 32'd0);
        chk("rst_ready", {30'd0, wr_ready, frame_ready}, 32'd3);
    endtask

    initial begin
        int popped;
        int wr_idx;
        int rd_idx;
        logic pop_exp;

        //                 we pk     fc tk rn  empty fp  cpkt pkt
        vt[0]  = mk(1, 30'h1, 0, 0, 0, 1, 8'd0, 0, 30'h0);
        vt[1]  = mk(1, 30'h2, 0, 0, 0, 1, 8'd0, 0, 30'h0);
        vt[2]  = mk(1, 30'h3, 0, 0, 0, 1, 8'd0, 0, 30'h0);
        vt[3]  = mk(0, 30'h0, 1, 0, 0, 1, 8'd1, 0, 30'h0);
        vt[4]  = mk(0, 30'h0, 0, 1, 0, 0, 8'd0, 1, 30'h0);
        vt[5]  = mk(0, 30'h0, 0, 0, 1, 0, 8'd0, 1, 30'h1);
        vt[6]  = mk(0, 30'h0, 0, 0, 1, 0, 8'd0, 1, 30'h2);
        vt[7]  = mk(0, 30'h0, 0, 0, 1, 1, 8'd0, 1, 30'h3);
        vt[8]  = mk(0, 30'h0, 0, 0, 0, 1, 8'd0, 1, 30'h3);
        vt[9]  = mk(1, 30'hA, 0, 0, 0, 1, 8'd0, 0, 30'h0);
        vt[10] = mk(1, 30'hB, 0, 0, 0, 1, 8'd0, 0, 30'h0);
        vt[11] = mk(0, 30'h0, 1, 0, 0, 1, 8'd1, 0, 30'h0);
        vt[12] = mk(0, 30'h0, 1, 0, 0, 1, 8'd2, 0, 30'h0);
        vt[13] = mk(0, 30'h0, 0, 1, 0, 0, 8'd1, 0, 30'h0);
        vt[14] = mk(0, 30'h0, 0, 0, 1, 0, 8'd1, 1, 30'hA);
        vt[15] = mk(0, 30'h0, 0, 0, 1, 1, 8'd1, 1, 30'hB);
        vt[16] = mk(0, 30'h0, 0, 1, 0, 1, 8'd0, 1, 30'hB);
        vt[17] = mk(0, 30'h0, 0, 0, 0, 1, 8'd0, 1, 30'hB);

        reset_n = 1'b0; wr_en = 0; wr_packet = '0; frame_close = 0; tick = 0; ren = 0;
        do_reset();
        chk_reset_state();

        for (int i = 0; i < 18; i++) begin
            cyc(vt[i].we, vt[i].pk, vt[i].fc, vt[i].tk, vt[i].rn);
            chk($sformatf("v%0d_empty", i), {31'd0, empty}, {31'd0, vt[i].e_empty});
            chk($sformatf("v%0d_fp", i), {24'd0, frames_pending}, {24'd0, vt[i].e_fp});
            if (vt[i].c_pkt) chk($sformatf("v%0d_pkt", i), {2'd0, packet_in}, {2'd0, vt[i].e_pkt});
        end
        chk("basic_flags", {27'd0, wr_overflow, frame_overflow, tick_underrun, frame_truncated, ren_while_empty}, 32'd0);

        // Truncation: frame of 5, pop 2, tick with a 1-packet frame pending.
        for (int i = 0; i < 5; i++) cyc(1, 30'h10 + PW'(i), 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(1, 30'h20, 1, 0, 0);
        chk("tr_fp2", {24'd0, frames_pending}, 32'd2);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        chk("tr_pk0", {2'd0, packet_in}, 32'h10);
        cyc(0, 0, 0, 0, 1);
        chk("tr_pk1", {2'd0, packet_in}, 32'h11);
        cyc(0, 0, 0, 1, 0);
        chk("tr_flag", {31'd0, frame_truncated}, 32'd1);
        chk("tr_drop", {19'd0, dropped_count}, 32'd3);
        chk("tr_empty", {31'd0, empty}, 32'd0);
        cyc(0, 0, 0, 0, 1);
        chk("tr_newpk", {2'd0, packet_in}, 32'h20);
        chk("tr_empty_end", {31'd0, empty}, 32'd1);

        // Underrun then ren while empty.
        cyc(0, 0, 0, 1, 0);
        chk("ur_flag", {31'd0, tick_underrun}, 32'd1);
        chk("ur_empty", {31'd0, empty}, 32'd1);
        cyc(0, 0, 0, 0, 1);
        chk("rwe_flag", {31'd0, ren_while_empty}, 32'd1);
        chk("rwe_pkt", {2'd0, packet_in}, 32'h20);

        // Fill the store, overflow once, then stream the full frame back.
        do_reset();
        chk_reset_state();
        for (int i = 0; i < DEPTH; i++) cyc(1, PW'(i), 0, 0, 0);
        chk("full_wr_ready", {31'd0, wr_ready}, 32'd0);
        chk("full_no_ovf", {31'd0, wr_overflow}, 32'd0);
        cyc(1, 30'hDEAD, 0, 0, 0);
        chk("full_ovf", {31'd0, wr_overflow}, 32'd1);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0);
        popped = 0;
        for (int i = 0; i < DEPTH + 10 && !empty; i++) begin
            cyc(0, 0, 0, 0, 1);
            if (packet_in !== PW'(popped)) chk("full_data", {2'd0, packet_in}, popped);
            popped++;
        end
        chk("full_popcnt", popped, DEPTH);
        chk("full_pk_last", {2'd0, packet_in}, DEPTH - 1);
        chk("full_ready_back", {31'd0, wr_ready}, 32'd1);

        for (int i = 0; i < FD; i++) cyc(0, 0, 1, 0, 0);
        chk("ff_fp", {24'd0, frames_pending}, FD);
        chk("ff_ready", {31'd0, frame_ready}, 32'd0);
        chk("ff_no_ovf", {31'd0, frame_overflow}, 32'd0);
        cyc(0, 0, 1, 0, 0);
        chk("ff_ovf", {31'd0, frame_overflow}, 32'd1);
        chk("ff_fp_hold", {24'd0, frames_pending}, FD);

        // Wrap: 3 frames of 3000, writes of the next frame overlap pops of the current one.
        do_reset();
        for (int i = 0; i < 3000; i++) cyc(1, PW'(i), (i == 2999), 0, 0);
        chk("wrap_fp1", {24'd0, frames_pending}, 32'd1);
        cyc(0, 0, 0, 1, 0);
        wr_idx = 3000;
        rd_idx = 0;
        for (int f = 1; f < 3; f++) begin
            for (int i = 0; i < 3000; i++) begin
                @(negedge clk);
                pop_exp = !empty;
                wr_en = 1; wr_packet = PW'(wr_idx); frame_close = (i == 2999); tick = 0; ren = pop_exp;
                @(posedge clk);
                #1;
                wr_idx++;
                if (pop_exp) begin
                    if (packet_in !== PW'(rd_idx)) chk("wrap_data", {2'd0, packet_in}, rd_idx);
                    rd_idx++;
                end
            end
            cyc(0, 0, 0, 1, 0);
        end
        for (int i = 0; i < 4000 && !empty; i++) begin
            cyc(0, 0, 0, 0, 1);
            if (packet_in !== PW'(rd_idx)) chk("wrap_data", {2'd0, packet_in}, rd_idx);
            rd_idx++;
        end
        chk("wrap_count", rd_idx, 9000);
        chk("wrap_empty", {31'd0, empty}, 32'd1);
        chk("wrap_fp0", {24'd0, frames_pending}, 32'd0);
        chk("wrap_flags", {27'd0, wr_overflow, frame_overflow, tick_underrun, frame_truncated, ren_while_empty}, 32'd0);

        // An empty level means exactly DEPTH further writes fit.
        for (int i = 0; i < DEPTH - 1; i++) cyc(1, 0, 0, 0, 0);
        chk("lvl_not_full", {31'd0, wr_ready}, 32'd1);
        cyc(1, 0, 0, 0, 0);
        chk("lvl_full", {31'd0, wr_ready}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
